seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 19 +
 rtl/seg7_scan_ctrl.sv | 111 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: segment table,
// CTRL field positions and the register reset values.
package seg7_pkg;

  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_EN_LSB   = 8;
  localparam int CTRL_DP_LSB   = 16;
  localparam int MASK_W        = 8;

  localparam logic [31:0] CTRL_RST = 32'h0000_FF00;
  localparam logic [31:0] DATA_RST = 32'h0000_0000;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with blanking and decimal point;
// all outputs are active-low.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] y
);

  always_comb begin
    y = 8'hFF;
    if (!blank) begin
      y = {~dp, ~SEG_LUT[value]};
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, shadow
// registers that reach the display only at frame boundaries, registered outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int PRESCALE = 1
) (
  input  logic            clkout,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_addr,
  input  logic [31:0]     wr_data,
  output logic [NDIG-1:0] DIG,
  output logic [7:0]      Y
);

  localparam int              IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [15:0]     PS_LAST  = 16'(PRESCALE - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);

  logic [15:0]     ps_cnt;
  logic [IW-1:0]   idx;
  logic [31:0]     sh_data;
  logic [31:0]     sh_ctrl;
  logic [31:0]     act_data;
  logic [31:0]     act_ctrl;
  logic [31:0]     sh_data_next;
  logic [31:0]     sh_ctrl_next;
  logic            tick;
  logic            wrap;
  logic [3:0]      cur_val;
  logic            cur_en;
  logic            cur_dp;
  logic [NDIG-1:0] dig_next;
  logic [7:0]      y_next;
  logic            ctrl_unused;

  assign tick = (ps_cnt == PS_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // The frame copy takes the post-write shadow so a write on the wrap edge lands at once
  assign sh_data_next = (wr_en && (wr_addr == ADDR_DATA)) ? wr_data : sh_data;
  assign sh_ctrl_next = (wr_en && (wr_addr == ADDR_CTRL)) ? wr_data : sh_ctrl;

  assign ctrl_unused = ^{act_ctrl[31:24], act_ctrl[7:1]};

  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      ps_cnt <= '0;
      idx    <= '0;
    end else begin
      ps_cnt <= tick ? 16'd0 : ps_cnt + 16'd1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      sh_data  <= DATA_RST;
      sh_ctrl  <= CTRL_RST;
      act_data <= DATA_RST;
      act_ctrl <= CTRL_RST;
    end else begin
      sh_data <= sh_data_next;
      sh_ctrl <= sh_ctrl_next;
      if (wrap) begin
        act_data <= sh_data_next;
        act_ctrl <= sh_ctrl_next;
      end
    end
  end

  always_comb begin
    cur_val  = 4'h0;
    cur_en   = 1'b0;
    cur_dp   = 1'b0;
    dig_next = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        cur_val     = act_ctrl[CTRL_MODE_BIT] ? act_data[4*i +: 4] : {3'b000, act_data[i]};
        cur_en      = act_ctrl[CTRL_EN_LSB + i];
        cur_dp      = act_ctrl[CTRL_DP_LSB + i];
        dig_next[i] = 1'b0;
      end
    end
    if (!cur_en) begin
      dig_next = '1;
    end
  end

  seg7_decode u_decode (
    .value (cur_val),
    .blank (!cur_en),
    .dp    (cur_dp),
    .y     (y_next)
  );

  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      DIG <= '1;
      Y   <= 8'hFF;
    end else begin
      DIG <= dig_next;
      Y   <= y_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: three instances cover the fast scan,
// a prescaled scan and the single-digit corner.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic        rst_a, wr_en_a, wr_addr_a;
  logic [31:0] wr_data_a;
  logic [7:0]  dig_a, y_a;

  logic        rst_b, wr_en_b, wr_addr_b;
  logic [31:0] wr_data_b;
  logic [7:0]  dig_b, y_b;

  logic        rst_c, wr_en_c, wr_addr_c;
  logic [31:0] wr_data_c;
  logic [0:0]  dig_c;
  logic [7:0]  y_c;

  seg7_scan_ctrl #(.NDIG(8), .PRESCALE(1)) dut_a (
    .clkout(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .DIG(dig_a), .Y(y_a));

  seg7_scan_ctrl #(.NDIG(8), .PRESCALE(4)) dut_b (
    .clkout(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .DIG(dig_b), .Y(y_b));

  seg7_scan_ctrl #(.NDIG(1), .PRESCALE(1)) dut_c (
    .clkout(clk), .rst(rst_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
    .wr_data(wr_data_c), .DIG(dig_c), .Y(y_c));

  localparam logic [63:0] DIG_CYC = 64'h7FBF_DFEF_F7FB_FDFE;
  localparam logic [63:0] DIG_S3  = 64'hFFFF_FFFF_F7FB_FDFE;
  localparam logic [63:0] Y_ZERO  = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] Y_S2    = 64'hF9C0_F9C0_C0F9_C0F9;
  localparam logic [63:0] Y_S3    = 64'hFFFF_FFFF_9282_F800;
  localparam logic [63:0] Y_S5    = 64'hFFFF_FFFF_C088_8346;
  localparam logic [63:0] Y_S6    = 64'hC0C0_C0C0_C088_83C6;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One scan step per sample; writes are driven ahead of the edge that processes index k
  task automatic frame_a(input string tag, input logic [63:0] edig, input logic [63:0] ey,
                         input int wr_at, input int nwr, input logic [2:0] waddr,
                         input logic [95:0] wdata, input int nk);
    for (int k = 0; k < nk; k++) begin
      if (k >= wr_at && k < wr_at + nwr) begin
        wr_en_a   = 1'b1;
        wr_addr_a = waddr[k - wr_at];
        wr_data_a = wdata[32*(k - wr_at) +: 32];
      end else begin
        wr_en_a = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("%s dig%0d", tag, k), dig_a, edig[8*k +: 8]);
      chk($sformatf("%s y%0d", tag, k), y_a, ey[8*k +: 8]);
    end
    wr_en_a = 1'b0;
  endtask

  task automatic frame_b(input string tag, input logic [7:0] ey, input int wr_at,
                         input logic [31:0] wdata);
    logic [7:0] edig;
    for (int k = 0; k < 8; k++) begin
      edig = ~(8'h01 << k);
      for (int c = 0; c < 4; c++) begin
        if (k == wr_at && c == 0) begin
          wr_en_b   = 1'b1;
          wr_addr_b = 1'b0;
          wr_data_b = wdata;
        end else begin
          wr_en_b = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("%s dig%0d.%0d", tag, k, c), dig_b, edig);
        chk($sformatf("%s y%0d.%0d", tag, k, c), y_b, ey);
      end
    end
    wr_en_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; wr_en_a = 1'b0; wr_addr_a = 1'b0; wr_data_a = '0;
    rst_b = 1'b1; wr_en_b = 1'b0; wr_addr_b = 1'b0; wr_data_b = '0;
    rst_c = 1'b1; wr_en_c = 1'b0; wr_addr_c = 1'b0; wr_data_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst a dig", dig_a, 8'hFF);
    chk("rst a y", y_a, 8'hFF);
    chk("rst b dig", dig_b, 8'hFF);
    chk("rst b y", y_b, 8'hFF);
    chk("rst c dig", {7'h7F, dig_c}, 8'hFF);
    chk("rst c y", y_c, 8'hFF);

    rst_a = 1'b0;
    frame_a("s1", DIG_CYC, Y_ZERO, -1, 0, 3'b000, 96'h0, 8);
    frame_a("s2 old", DIG_CYC, Y_ZERO, 0, 1, 3'b000, 96'h0000_00A5, 8);
    frame_a("s2", DIG_CYC, Y_S2, 0, 3, 3'b001,
            {32'h1234_5678, 32'hDEAD_BEEF, 32'h0001_0F01}, 8);
    frame_a("s3", DIG_S3, Y_S3, 7, 1, 3'b000, 96'h0000_0ABC, 8);
    frame_a("s5", DIG_S3, Y_S5, 3, 1, 3'b001, 96'h0000_FF01, 8);
    frame_a("s6 pre", DIG_CYC, Y_S6, 1, 1, 3'b000, 96'hFFFF_FFFF, 6);

    #2 rst_a = 1'b1;
    #1;
    chk("s6 async dig", dig_a, 8'hFF);
    chk("s6 async y", y_a, 8'hFF);
    @(negedge clk);
    chk("s6 held dig", dig_a, 8'hFF);
    chk("s6 held y", y_a, 8'hFF);
    rst_a = 1'b0;
    frame_a("s6 post", DIG_CYC, Y_ZERO, -1, 0, 3'b000, 96'h0, 8);
    frame_a("s6 discard", DIG_CYC, Y_ZERO, -1, 0, 3'b000, 96'h0, 8);

    rst_b = 1'b0;
    frame_b("s4 old", 8'hC0, 3, 32'h0000_00FF);
    frame_b("s4 new", 8'hF9, -1, 32'h0);

    rst_c = 1'b0;
    @(negedge clk);
    chk("c first dig", {7'h00, dig_c}, 8'h00);
    chk("c first y", y_c, 8'hC0);
    wr_en_c = 1'b1; wr_addr_c = 1'b0; wr_data_c = 32'h0000_0001;
    @(negedge clk);
    wr_en_c = 1'b0;
    chk("c wr edge y", y_c, 8'hC0);
    @(negedge clk);
    chk("c new dig", {7'h00, dig_c}, 8'h00);
    chk("c new y", y_c, 8'hF9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
